// File: rtl/div_unit_32_pkg.sv
// Shared types and sizing for the 32-bit iterative divider.
package div_unit_32_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_unit_32_sub.sv
// 32-bit subtractor; borrow is set when b > a (unsigned).
module Sub32Bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_unit_32.sv
// Signed/unsigned 32-bit restoring divider: 32 shift-subtract steps, then sign fix-up.
module div_unit_32
    import div_unit_32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sign,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Q,
    output logic [DATA_W-1:0] R,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic              qneg_q, rneg_q, bzero_q;

    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W-1:0] shift_rem, trial;
    logic              sub_borrow, keep;
    logic [DATA_W-1:0] q_fix, r_fix;

    assign a_mag = (sign && A[DATA_W-1]) ? -A : A;
    assign b_mag = (sign && B[DATA_W-1]) ? -B : B;

    // Bit shifted out of rem is the 33rd bit of the trial; if set, the subtract cannot borrow.
    assign shift_rem = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};

    Sub32Bit u_sub (
        .a      (shift_rem),
        .b      (dvs_q),
        .diff   (trial),
        .borrow (sub_borrow)
    );

    assign keep = rem_q[DATA_W-1] | ~sub_borrow;

    // A zero divisor runs the normal steps (rem ends as |A|, restored by the sign fix).
    assign q_fix = bzero_q ? '1 : (qneg_q ? -quo_q : quo_q);
    assign r_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (cnt_q == 5'(ITER_COUNT - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= a_mag;
                        dvs_q   <= b_mag;
                        qneg_q  <= sign & (A[DATA_W-1] ^ B[DATA_W-1]);
                        rneg_q  <= sign & A[DATA_W-1];
                        bzero_q <= (B == '0);
                    end
                end
                BUSY: begin
                    rem_q <= keep ? trial : shift_rem;
                    quo_q <= {quo_q[DATA_W-2:0], keep};
                    cnt_q <= cnt_q + 5'd1;
                end
                FIX: begin
                    Q        <= q_fix;
                    R        <= r_fix;
                    div_zero <= bzero_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_32.sv
// Directed bench for div_unit_32: latency, signed/unsigned results, corner cases, ignore/abort.
module tb_div_unit_32;

    logic        clk = 1'b0;
    logic        rst_n, start, sign;
    logic [31:0] a, b, q, r;
    logic        busy, done, div_zero;

    int total = 0;
    int bad   = 0;
    int lat;
    int pulses;

    div_unit_32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sign     (sign),
        .A        (a),
        .B        (b),
        .Q        (q),
        .R        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue start in the next cycle (cycle 0); return the cycle in which done was seen.
    task automatic run(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       output int cyc);
        @(negedge clk);
        start = 1'b1;
        sign  = s;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_q", q, 32'h0);
        chk("reset_r", r, 32'h0);
        chk("reset_flags", {29'h0, busy, done, div_zero}, 32'h0);
        rst_n = 1'b1;

        run(1'b0, 32'd100, 32'd7, lat);
        chk("u100_7_lat", lat, 34);
        chk("u100_7_q", q, 32'd14);
        chk("u100_7_r", r, 32'd2);
        chk("u100_7_dz", {31'h0, div_zero}, 32'h0);
        @(negedge clk);
        chk("u100_7_after", {30'h0, busy, done}, 32'h0);

        run(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        chk("s_m7_2_q", q, 32'hFFFF_FFFD);
        chk("s_m7_2_r", r, 32'hFFFF_FFFF);
        run(1'b0, 32'hFFFF_FFF9, 32'd2, lat);
        chk("u_m7_2_q", q, 32'h7FFF_FFFC);
        chk("u_m7_2_r", r, 32'h1);
        run(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
        chk("s_7_m2_q", q, 32'hFFFF_FFFD);
        chk("s_7_m2_r", r, 32'h1);

        run(1'b0, 32'h1234_5678, 32'h0, lat);
        chk("u_dz_lat", lat, 34);
        chk("u_dz_q", q, 32'hFFFF_FFFF);
        chk("u_dz_r", r, 32'h1234_5678);
        chk("u_dz_flag", {31'h0, div_zero}, 32'h1);
        run(1'b1, 32'h1234_5678, 32'h0, lat);
        chk("s_dz_q", q, 32'hFFFF_FFFF);
        chk("s_dz_r", r, 32'h1234_5678);
        chk("s_dz_flag", {31'h0, div_zero}, 32'h1);
        run(1'b1, 32'hFFFF_FFF9, 32'h0, lat);
        chk("s_dzneg_q", q, 32'hFFFF_FFFF);
        chk("s_dzneg_r", r, 32'hFFFF_FFF9);

        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("s_ovf_q", q, 32'h8000_0000);
        chk("s_ovf_r", r, 32'h0);
        chk("s_ovf_dz", {31'h0, div_zero}, 32'h0);
        run(1'b0, 32'hFFFF_FFFF, 32'h1, lat);
        chk("u_max_1_q", q, 32'hFFFF_FFFF);
        chk("u_max_1_r", r, 32'h0);

        // Starts during BUSY (cycle 5) and in DONE (cycle 34) must be ignored.
        @(negedge clk);
        start = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; sign = 1'b1; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        chk("ign_done34", {31'h0, done}, 32'h1);
        start = 1'b1; a = 32'd81; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy35", {31'h0, busy}, 32'h0);
        chk("ign_q", q, 32'd14);
        chk("ign_r", r, 32'd2);
        @(negedge clk);
        chk("ign_busy36", {31'h0, busy}, 32'h0);

        // Reset in cycle 10 aborts the operation without a done pulse.
        @(negedge clk);
        start = 1'b1; sign = 1'b0; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_q", q, 32'h0);
        chk("abort_r", r, 32'h0);
        chk("abort_flags", {29'h0, busy, done, div_zero}, 32'h0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        run(1'b0, 32'd9, 32'd3, lat);
        chk("post_lat", lat, 34);
        chk("post_q", q, 32'd3);
        chk("post_r", r, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
